mem_port_arbiter: RTL and testbench

- Arbitrates the single shared main-memory port between two requesters: the instruction fetch unit (IFU) and the load/store unit (LSU).
- Sits between IFU/LSU and the memory interface. Sequences one transaction at a time with a request/grant/valid handshake.
- Priority is fixed LSU-first, with a starvation guard for IFU and a per-transaction timeout.

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared main-memory port arbiter for IFU and LSU: fixed LSU priority with an
// IFU starvation guard and a per-transaction timeout, one transaction at a time.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  ifu_req_in,
  input  logic [ADDR_WIDTH-1:0] ifu_addr_in,
  output logic                  ifu_grant_out,
  output logic                  ifu_valid_out,
  output logic [DATA_WIDTH-1:0] ifu_data_out,
  input  logic                  lsu_req_in,
  input  logic                  lsu_we_in,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_in,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_in,
  output logic                  lsu_grant_out,
  output logic                  lsu_valid_out,
  output logic [DATA_WIDTH-1:0] lsu_data_out,
  output logic                  err_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_wdata_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  input  logic [DATA_WIDTH-1:0] mem_rdata_in,
  input  logic                  mem_valid_in,
  output logic                  busy_out,
  output logic                  timeout_flag_out
);

  typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_state_next;
  logic                  r_owner_lsu, w_owner_lsu_next;
  logic                  r_we, w_we_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_next;
  logic [SW-1:0]         r_starve_cnt, w_starve_cnt_next;
  logic [TW-1:0]         r_tmo_cnt, w_tmo_cnt_next;
  logic                  r_ifu_grant, w_ifu_grant_next;
  logic                  r_lsu_grant, w_lsu_grant_next;
  logic                  r_ifu_valid, w_ifu_valid_next;
  logic                  r_lsu_valid, w_lsu_valid_next;
  logic                  r_err, w_err_next;
  logic [DATA_WIDTH-1:0] r_ifu_data, w_ifu_data_next;
  logic [DATA_WIDTH-1:0] r_lsu_data, w_lsu_data_next;
  logic                  r_mem_read, w_mem_read_next;
  logic                  r_mem_write, w_mem_write_next;
  logic                  r_tmo_flag, w_tmo_flag_next;

  logic w_lsu_win;
  logic w_ifu_win;

  // IFU overrides LSU priority only once it has lost STARVE_LIMIT times in a row.
  assign w_lsu_win = lsu_req_in && (!ifu_req_in || (r_starve_cnt < STARVE_MAX));
  assign w_ifu_win = ifu_req_in && !w_lsu_win;

  always_comb begin
    w_state_next      = r_state;
    w_owner_lsu_next  = r_owner_lsu;
    w_we_next         = r_we;
    w_addr_next       = r_addr;
    w_wdata_next      = r_wdata;
    w_starve_cnt_next = r_starve_cnt;
    w_tmo_cnt_next    = r_tmo_cnt;
    w_ifu_grant_next  = 1'b0;
    w_lsu_grant_next  = 1'b0;
    w_ifu_valid_next  = 1'b0;
    w_lsu_valid_next  = 1'b0;
    w_err_next        = 1'b0;
    w_ifu_data_next   = r_ifu_data;
    w_lsu_data_next   = r_lsu_data;
    w_mem_read_next   = r_mem_read;
    w_mem_write_next  = r_mem_write;
    w_tmo_flag_next   = r_tmo_flag;

    case (r_state)
      ST_IDLE: begin
        if (w_lsu_win) begin
          w_state_next     = ST_XFER;
          w_owner_lsu_next = 1'b1;
          w_we_next        = lsu_we_in;
          w_addr_next      = lsu_addr_in;
          w_wdata_next     = lsu_wdata_in;
          w_tmo_cnt_next   = '0;
          w_lsu_grant_next = 1'b1;
          w_mem_read_next  = !lsu_we_in;
          w_mem_write_next = lsu_we_in;
          if (ifu_req_in && (r_starve_cnt < STARVE_MAX)) begin
            w_starve_cnt_next = r_starve_cnt + 1'b1;
          end
        end else if (w_ifu_win) begin
          w_state_next      = ST_XFER;
          w_owner_lsu_next  = 1'b0;
          w_we_next         = 1'b0;
          w_addr_next       = ifu_addr_in;
          w_wdata_next      = '0;
          w_tmo_cnt_next    = '0;
          w_ifu_grant_next  = 1'b1;
          w_mem_read_next   = 1'b1;
          w_mem_write_next  = 1'b0;
          w_starve_cnt_next = '0;
        end
      end

      ST_XFER: begin
        // Completion takes precedence over a timeout landing on the same cycle.
        if (mem_valid_in || (r_tmo_cnt == TMO_LAST)) begin
          w_state_next     = ST_IDLE;
          w_mem_read_next  = 1'b0;
          w_mem_write_next = 1'b0;
          w_ifu_valid_next = !r_owner_lsu;
          w_lsu_valid_next = r_owner_lsu;
          if (!mem_valid_in) begin
            w_err_next      = 1'b1;
            w_tmo_flag_next = 1'b1;
          end
          if (!r_we) begin
            if (r_owner_lsu) begin
              w_lsu_data_next = mem_valid_in ? mem_rdata_in : '0;
            end else begin
              w_ifu_data_next = mem_valid_in ? mem_rdata_in : '0;
            end
          end
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + 1'b1;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state      <= ST_IDLE;
      r_owner_lsu  <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_ifu_grant  <= 1'b0;
      r_lsu_grant  <= 1'b0;
      r_ifu_valid  <= 1'b0;
      r_lsu_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_ifu_data   <= '0;
      r_lsu_data   <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_tmo_flag   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_owner_lsu  <= w_owner_lsu_next;
      r_we         <= w_we_next;
      r_addr       <= w_addr_next;
      r_wdata      <= w_wdata_next;
      r_starve_cnt <= w_starve_cnt_next;
      r_tmo_cnt    <= w_tmo_cnt_next;
      r_ifu_grant  <= w_ifu_grant_next;
      r_lsu_grant  <= w_lsu_grant_next;
      r_ifu_valid  <= w_ifu_valid_next;
      r_lsu_valid  <= w_lsu_valid_next;
      r_err        <= w_err_next;
      r_ifu_data   <= w_ifu_data_next;
      r_lsu_data   <= w_lsu_data_next;
      r_mem_read   <= w_mem_read_next;
      r_mem_write  <= w_mem_write_next;
      r_tmo_flag   <= w_tmo_flag_next;
    end
  end

  assign ifu_grant_out    = r_ifu_grant;
  assign lsu_grant_out    = r_lsu_grant;
  assign ifu_valid_out    = r_ifu_valid;
  assign lsu_valid_out    = r_lsu_valid;
  assign ifu_data_out     = r_ifu_data;
  assign lsu_data_out     = r_lsu_data;
  assign err_out          = r_err;
  assign mem_addr_out     = r_addr;
  assign mem_wdata_out    = r_wdata;
  assign mem_read_out     = r_mem_read;
  assign mem_write_out    = r_mem_write;
  assign busy_out         = (r_state == ST_XFER);
  assign timeout_flag_out = r_tmo_flag;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, priority, starvation guard,
// timeout, completion-vs-timeout tie and asynchronous reset mid-transfer.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_grant;
  logic        ifu_valid;
  logic [31:0] ifu_data;
  logic        lsu_req;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_grant;
  logic        lsu_valid;
  logic [31:0] lsu_data;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        busy;
  logic        tmo_flag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .STARVE_LIMIT(4)
  ) dut (
    .clock_in(clk), .reset_in(rst_n),
    .ifu_req_in(ifu_req), .ifu_addr_in(ifu_addr),
    .ifu_grant_out(ifu_grant), .ifu_valid_out(ifu_valid), .ifu_data_out(ifu_data),
    .lsu_req_in(lsu_req), .lsu_we_in(lsu_we), .lsu_addr_in(lsu_addr),
    .lsu_wdata_in(lsu_wdata), .lsu_grant_out(lsu_grant), .lsu_valid_out(lsu_valid),
    .lsu_data_out(lsu_data), .err_out(err),
    .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata),
    .mem_read_out(mem_read), .mem_write_out(mem_write),
    .mem_rdata_in(mem_rdata), .mem_valid_in(mem_valid),
    .busy_out(busy), .timeout_flag_out(tmo_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_lsu_order [6];

  initial begin
    exp_lsu_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0; ifu_req = 1'b0; ifu_addr = '0; lsu_req = 1'b0; lsu_we = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; mem_rdata = '0; mem_valid = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_outs", {26'd0, ifu_grant, lsu_grant, ifu_valid, lsu_valid, err, tmo_flag}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // mem_valid_in in IDLE must be ignored
    mem_valid = 1'b1; mem_rdata = 32'hFFFF_0000;
    tick();
    chk("idle_valid_ignored", {30'd0, ifu_valid, lsu_valid}, 32'd0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);
    mem_valid = 1'b0;
    $display("[TB] idle mem_valid ignored");

    // IFU-only read, memory answers in the third strobe cycle
    ifu_req = 1'b1; ifu_addr = 32'h10;
    tick();
    chk("t1_grant", {30'd0, ifu_grant, lsu_grant}, 32'd2);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_read", {30'd0, mem_read, mem_write}, 32'd2);
    tick();
    chk("t1_grant_pulse", {31'd0, ifu_grant}, 32'd0);
    chk("t1_read2", {31'd0, mem_read}, 32'd1);
    tick();
    chk("t1_read3", {31'd0, mem_read}, 32'd1);
    mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t1_valid", {30'd0, ifu_valid, lsu_valid}, 32'd2);
    chk("t1_data", ifu_data, 32'hDEAD_BEEF);
    chk("t1_idle", {30'd0, busy, mem_read}, 32'd0);
    chk("t1_err", {31'd0, err}, 32'd0);
    mem_valid = 1'b0; ifu_req = 1'b0;
    tick();
    chk("t1_valid_pulse", {31'd0, ifu_valid}, 32'd0);
    chk("t1_data_held", ifu_data, 32'hDEAD_BEEF);
    $display("[TB] IFU read 0x10 -> 0x%08h", ifu_data);

    // Simultaneous IFU read and LSU write: LSU first
    ifu_req = 1'b1; ifu_addr = 32'h20;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h40; lsu_wdata = 32'h1234_5678;
    tick();
    chk("t2_grant_lsu", {30'd0, ifu_grant, lsu_grant}, 32'd1);
    chk("t2_write", {30'd0, mem_read, mem_write}, 32'd1);
    chk("t2_addr", mem_addr, 32'h40);
    chk("t2_wdata", mem_wdata, 32'h1234_5678);
    mem_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    chk("t2_lsu_valid", {30'd0, ifu_valid, lsu_valid}, 32'd1);
    chk("t2_lsu_data_kept", lsu_data, 32'd0);
    mem_valid = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0;
    tick();
    chk("t2_grant_ifu", {30'd0, ifu_grant, lsu_grant}, 32'd2);
    chk("t2_ifu_addr", mem_addr, 32'h20);
    mem_valid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    chk("t2_ifu_valid", {31'd0, ifu_valid}, 32'd1);
    chk("t2_ifu_data", ifu_data, 32'h1111_2222);
    mem_valid = 1'b0; ifu_req = 1'b0;
    $display("[TB] LSU write 0x40 then IFU read 0x20 -> 0x%08h", ifu_data);

    // Both requesting continuously: LSU x4, IFU, LSU
    ifu_req = 1'b1; ifu_addr = 32'h30;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h50;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t3_grant%0d", i), {30'd0, ifu_grant, lsu_grant},
          exp_lsu_order[i] ? 32'd1 : 32'd2);
      mem_valid = 1'b1; mem_rdata = 32'(i + 100);
      tick();
      chk($sformatf("t3_valid%0d", i), {30'd0, ifu_valid, lsu_valid},
          exp_lsu_order[i] ? 32'd1 : 32'd2);
      mem_valid = 1'b0;
      $display("[TB] starve grant %0d -> %s", i, lsu_valid ? "LSU" : "IFU");
    end
    chk("t3_lsu_data", lsu_data, 32'd105);
    chk("t3_ifu_data", ifu_data, 32'd104);
    ifu_req = 1'b0; lsu_req = 1'b0;
    tick();

    // LSU read times out after 16 XFER cycles
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h80;
    tick();
    chk("t4_grant", {31'd0, lsu_grant}, 32'd1);
    repeat (15) tick();
    chk("t4_still_busy", {30'd0, busy, lsu_valid}, 32'd2);
    tick();
    chk("t4_valid_err", {29'd0, lsu_valid, err, tmo_flag}, 32'd7);
    chk("t4_data_zero", lsu_data, 32'd0);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    lsu_req = 1'b0;
    tick();
    chk("t4_err_pulse", {30'd0, err, tmo_flag}, 32'd1);
    $display("[TB] LSU read 0x80 timed out, flag=%0d", tmo_flag);

    // Completion on the last timeout cycle wins
    ifu_req = 1'b1; ifu_addr = 32'hC0;
    tick();
    chk("t5_grant", {31'd0, ifu_grant}, 32'd1);
    repeat (15) tick();
    mem_valid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    tick();
    chk("t5_valid_noerr", {29'd0, ifu_valid, err, tmo_flag}, 32'd5);
    chk("t5_data", ifu_data, 32'hA5A5_A5A5);
    mem_valid = 1'b0; ifu_req = 1'b0;
    $display("[TB] IFU read 0xC0 tie -> 0x%08h", ifu_data);

    // Reset mid-XFER, pending IFU request re-granted afterwards
    tick();
    ifu_req = 1'b1; ifu_addr = 32'hF0;
    tick();
    chk("t6_grant", {31'd0, ifu_grant}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", {27'd0, busy, mem_read, ifu_valid, err, tmo_flag}, 32'd0);
    chk("t6_rst_addr", mem_addr, 32'd0);
    chk("t6_rst_data", ifu_data, 32'd0);
    tick();
    chk("t6_no_valid", {30'd0, ifu_valid, lsu_valid}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("t6_regrant", {30'd0, ifu_grant, busy}, 32'd3);
    chk("t6_regrant_addr", mem_addr, 32'hF0);
    mem_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    chk("t6_valid", {31'd0, ifu_valid}, 32'd1);
    chk("t6_data", ifu_data, 32'h0BAD_F00D);
    mem_valid = 1'b0; ifu_req = 1'b0;
    $display("[TB] reset mid-XFER then IFU read 0xF0 -> 0x%08h", ifu_data);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
